data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter CHAR_DEPTH, default 8, char FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port async_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clk_en  in  1  global advance enable, same as the CPU's.
REQ-005 SHALL have port mem_req  in  1  CPU data access request.
REQ-006 SHALL have port mem_we  in  1  write when high, read when low; qualified by mem_req.
REQ-007 SHALL have port data_address  in  8  byte address.
REQ-008 SHALL have port data_out  in  8  CPU write data.
REQ-009 SHALL have port data_in  out  8  read data returned to CPU.
REQ-010 SHALL have port num_value  out  8  number-display value; num_signed  out  1  signed-display flag.
REQ-011 SHALL have port buttons  in  8  asynchronous controller inputs.
REQ-012 SHALL have ports char_valid out 1, char_data out 8, char_ready in 1: character output stream.

Function
REQ-013 Access accepted only on clk edge with clk_en=1 and mem_req=1; otherwise no state change.
REQ-014 Map: 0x00-0xEF RAM (240 B, r/w); 0xF0 NUM (W); 0xF1 NUM_SGN (W bit0); 0xF2 NUM_CLR (W strobe); 0xF3 RNG (R); 0xF4 BTN (R); 0xF5 CHAR (W push); 0xF6 CHAR_FLUSH (W strobe); 0xF7 STATUS (R).
REQ-015 Read latency exactly one enabled cycle: data_in registered on the accepting edge, held until next accepted read, unchanged on writes or clk_en=0.
REQ-016 Unmapped or write-only address reads return 0x00; writes to read-only addresses ignored.
REQ-017 NUM_CLR write: num_value<=0, num_signed<=0.
REQ-018 BTN: buttons through 2-flop synchronizer clocked every edge regardless of clk_en; read returns synchronized value.
REQ-019 CHAR write: push data_out[7:0] when FIFO not full; when full, dropped and sticky overflow set.
REQ-020 Pop when char_valid & char_ready & clk_en; char_valid = FIFO not empty; char_data = head entry.
REQ-021 Push while full with pop same cycle: push accepted, no overflow.
REQ-022 CHAR_FLUSH empties FIFO, priority over same-cycle pop; overflow not cleared.
REQ-023 STATUS: bit7 overflow, bit6 full, bit5 empty, bit4 0, bits3:0 count; read clears overflow (set in same cycle wins).
REQ-024 Pointers wrap modulo CHAR_DEPTH; count 0..CHAR_DEPTH.

Reset
REQ-025 async_rst_n low: data_in=0, num_value=0, num_signed=0, FIFO empty (char_valid=0), overflow=0, synchronizer=0, LFSR=0x01.
REQ-026 Reset mid-access aborts it; RAM contents not reset, not altered.
REQ-027 Reset deassertion does not itself accept an access; first access needs a later enabled edge.

Configuration
REQ-028 Macro DMEM_RNG_EN defined: RNG read returns current 8-bit Fibonacci LFSR (taps 8,6,5,4, shift left, feedback into bit0), then advances one step.
REQ-029 DMEM_RNG_EN undefined: no LFSR logic; RNG reads return 0x00.

Structure
REQ-030 Package dmem_pkg SHALL hold address constants (ADDR_NUM ... ADDR_STATUS), RAM_TOP=0xEF, STATUS bit indices, LFSR seed.
REQ-031 FIFO SHALL be sub-module char_fifo (push, pop, flush, full, empty, count).

Verification
REQ-032 Write 0x5A to 0x10, read 0x10 -> data_in=0x5A one enabled cycle later; read 0xEF after writing 0xC3 -> 0xC3.
REQ-033 Write 0xF0=0x80, 0xF1=0x01 -> num_value=0x80, num_signed=1; write 0xF2 -> both 0.
REQ-034 char_ready=0, push 9 chars (depth 8) -> STATUS=0xC8; read again -> 0x48; raise char_ready -> chars 1..8 popped in order, STATUS=0x20.
REQ-035 Full FIFO, push with char_ready=1 same cycle -> count stays 8, overflow 0; flush with pop -> count 0.
REQ-036 With DMEM_RNG_EN: after reset, three RNG reads -> 0x01, 0x02, 0x04; without: 0x00 each.
REQ-037 clk_en=0 with mem_req=1, we=1 to 0x20 -> RAM unchanged, data_in held; async_rst_n pulse mid-burst -> outputs at reset values immediately.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: address map, STATUS bit layout and LFSR step shared by data_mem_responder.
// The LFSR helper is only referenced when DMEM_RNG_EN is defined.
package dmem_pkg;

   localparam logic [7:0]  RAM_TOP         = 8'hEF;
   localparam int unsigned RAM_BYTES       = 240;

   localparam logic [7:0]  ADDR_NUM        = 8'hF0;
   localparam logic [7:0]  ADDR_NUM_SGN    = 8'hF1;
   localparam logic [7:0]  ADDR_NUM_CLR    = 8'hF2;
   localparam logic [7:0]  ADDR_RNG        = 8'hF3;
   localparam logic [7:0]  ADDR_BTN        = 8'hF4;
   localparam logic [7:0]  ADDR_CHAR       = 8'hF5;
   localparam logic [7:0]  ADDR_CHAR_FLUSH = 8'hF6;
   localparam logic [7:0]  ADDR_STATUS     = 8'hF7;

   localparam int unsigned STATUS_OVF_BIT   = 7;
   localparam int unsigned STATUS_FULL_BIT  = 6;
   localparam int unsigned STATUS_EMPTY_BIT = 5;

   localparam logic [7:0]  LFSR_SEED       = 8'h01;

   // Fibonacci step, taps 8,6,5,4: shift left, feedback enters bit 0.
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction

endpackage

// File: rtl/char_fifo.sv
// char_fifo: character output FIFO with push, pop and flush.
// A push while full is accepted only when a pop happens in the same cycle; flush beats pop.
module char_fifo
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic                    flush_i,
   input  logic [7:0]              data_i,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic [7:0]              head_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i && !empty_o && !flush_i;
   assign push_ok = push_i && !flush_i && (!full_o || pop_ok);

   // NOTE: every _d signal gets its default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: clocked state uses non-blocking (<=) so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-bus slave with 240 B RAM, number display, buttons, char stream.
// Optional macro DMEM_RNG_EN adds the LFSR behind the RNG address; without it RNG reads return 0.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned CHAR_DEPTH = 8
) (
   input  logic       clk,
   input  logic       async_rst_n,
   input  logic       clk_en,
   input  logic       mem_req,
   input  logic       mem_we,
   input  logic [7:0] data_address,
   input  logic [7:0] data_out,
   output logic [7:0] data_in,
   output logic [7:0] num_value,
   output logic       num_signed,
   input  logic [7:0] buttons,
   output logic       char_valid,
   output logic [7:0] char_data,
   input  logic       char_ready
);

   localparam int unsigned CNT_W = $clog2(CHAR_DEPTH) + 1;

   logic             acc_wr, acc_rd, ram_wr;
   logic [7:0]       ram_q [RAM_BYTES];
   logic [7:0]       data_in_q, data_in_d;
   logic [7:0]       num_q, num_d;
   logic             sgn_q, sgn_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       btn_meta_q, btn_sync_q;
   logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [7:0]       status, rng_val, rd_data;

   assign acc_wr     = clk_en && mem_req && mem_we;
   assign acc_rd     = clk_en && mem_req && !mem_we;
   assign ram_wr     = acc_wr && (data_address <= RAM_TOP);
   assign fifo_push  = acc_wr && (data_address == ADDR_CHAR);
   assign fifo_flush = acc_wr && (data_address == ADDR_CHAR_FLUSH);
   assign fifo_pop   = char_valid && char_ready && clk_en;

   char_fifo #(
      .DEPTH   (CHAR_DEPTH)
   ) u_char_fifo (
      .clk     (clk),
      .rst_n   (async_rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .data_i  (data_out),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (char_data)
   );

`ifdef DMEM_RNG_EN
   logic       rng_rd;
   logic [7:0] lfsr_q;

   assign rng_rd  = acc_rd && (data_address == ADDR_RNG);
   assign rng_val = lfsr_q;

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n)  lfsr_q <= LFSR_SEED;
      else if (rng_rd)   lfsr_q <= lfsr_next(lfsr_q);
   end
`else
   assign rng_val = 8'h00;
`endif

   always_comb begin
      status                   = '0;
      status[STATUS_OVF_BIT]   = ovf_q;
      status[STATUS_FULL_BIT]  = fifo_full;
      status[STATUS_EMPTY_BIT] = fifo_empty;
      status[3:0]              = 4'(fifo_count);
   end

   always_comb begin
      rd_data = 8'h00;
      if (data_address <= RAM_TOP) begin
         rd_data = ram_q[data_address];
      end else begin
         case (data_address)
            ADDR_RNG:    rd_data = rng_val;
            ADDR_BTN:    rd_data = btn_sync_q;
            ADDR_STATUS: rd_data = status;
            default:     ;
         endcase
      end
   end

   always_comb begin
      data_in_d = data_in_q;
      num_d     = num_q;
      sgn_d     = sgn_q;
      ovf_d     = ovf_q;
      if (acc_rd) data_in_d = rd_data;
      if (acc_wr) begin
         case (data_address)
            ADDR_NUM:     num_d = data_out;
            ADDR_NUM_SGN: sgn_d = data_out[0];
            ADDR_NUM_CLR: begin
               num_d = 8'h00;
               sgn_d = 1'b0;
            end
            default:      ;
         endcase
      end
      // A drop in the same cycle as a STATUS read must stay visible, so set wins.
      if (acc_rd && (data_address == ADDR_STATUS)) ovf_d = 1'b0;
      if (fifo_push && fifo_full && !fifo_pop)     ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         data_in_q <= 8'h00;
         num_q     <= 8'h00;
         sgn_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         data_in_q <= data_in_d;
         num_q     <= num_d;
         sgn_q     <= sgn_d;
         ovf_q     <= ovf_d;
      end
   end

   // The synchronizer runs on every edge; it must not stall with the CPU.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         btn_meta_q <= 8'h00;
         btn_sync_q <= 8'h00;
      end else begin
         btn_meta_q <= buttons;
         btn_sync_q <= btn_meta_q;
      end
   end

   // Writes are suppressed while reset is held, so an interrupted access never lands in RAM.
   always_ff @(posedge clk) begin
      if (ram_wr && async_rst_n) ram_q[data_address] <= data_out;
   end

   assign data_in    = data_in_q;
   assign num_value  = num_q;
   assign num_signed = sgn_q;
   assign char_valid = !fifo_empty;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized stimulus against a queue/array model of the
// memory map, with a per-cycle compare process and literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_data_mem_responder;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       async_rst_n = 1'b1;
   logic       clk_en = 1'b0;
   logic       mem_req = 1'b0;
   logic       mem_we = 1'b0;
   logic       char_ready = 1'b0;
   logic [7:0] data_address = 8'h00;
   logic [7:0] data_out = 8'h00;
   logic [7:0] buttons = 8'h00;
   logic [7:0] data_in, num_value, char_data;
   logic       num_signed, char_valid;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Behavioural model state
   logic [7:0] m_ram [240];
   logic [7:0] m_data_in, m_num, m_sync1, m_sync2, m_lfsr;
   logic       m_sgn, m_ovf;
   logic [7:0] m_fifo [$];

   data_mem_responder #(
      .CHAR_DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .async_rst_n  (async_rst_n),
      .clk_en       (clk_en),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .data_address (data_address),
      .data_out     (data_out),
      .data_in      (data_in),
      .num_value    (num_value),
      .num_signed   (num_signed),
      .buttons      (buttons),
      .char_valid   (char_valid),
      .char_data    (char_data),
      .char_ready   (char_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [7:0] a);
      int n;
      n = m_fifo.size();
      if (a < 8'hF0) return m_ram[a];
      case (a)
`ifdef DMEM_RNG_EN
         8'hF3: return m_lfsr;
`endif
         8'hF4: return m_sync2;
         8'hF7: return {m_ovf, n == DEPTH, n == 0, 1'b0, 4'(n % 16)};
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk or negedge async_rst_n) begin
      bit pop, push_ok, drop, flush;
      logic [7:0] a;
      if (!async_rst_n) begin
         m_data_in = 8'h00;
         m_num     = 8'h00;
         m_sgn     = 1'b0;
         m_ovf     = 1'b0;
         m_sync1   = 8'h00;
         m_sync2   = 8'h00;
         m_lfsr    = 8'h01;
         m_fifo.delete();
      end else begin
         a       = data_address;
         pop     = clk_en && char_ready && (m_fifo.size() != 0);
         push_ok = 1'b0;
         drop    = 1'b0;
         flush   = 1'b0;
         if (clk_en && mem_req) begin
            if (!mem_we) begin
               m_data_in = m_read(a);
               if (a == 8'hF3) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
               if (a == 8'hF7) m_ovf = 1'b0;
            end else if (a < 8'hF0) begin
               m_ram[a] = data_out;
            end else begin
               case (a)
                  8'hF0: m_num = data_out;
                  8'hF1: m_sgn = data_out[0];
                  8'hF2: begin m_num = 8'h00; m_sgn = 1'b0; end
                  8'hF5: if (m_fifo.size() < DEPTH || pop) push_ok = 1'b1; else drop = 1'b1;
                  8'hF6: flush = 1'b1;
                  default: ;
               endcase
            end
         end
         if (flush) begin
            m_fifo.delete();
         end else begin
            if (pop) void'(m_fifo.pop_front());
            if (push_ok) m_fifo.push_back(data_out);
         end
         if (drop) m_ovf = 1'b1;
         m_sync2 = m_sync1;
         m_sync1 = buttons;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("data_in", data_in, m_data_in);
         check("num_value", num_value, m_num);
         check("num_signed", {7'b0, num_signed}, {7'b0, m_sgn});
         check("char_valid", {7'b0, char_valid}, {7'b0, m_fifo.size() != 0});
         if (m_fifo.size() != 0) check("char_data", char_data, m_fifo[0]);
      end
   end

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      clk_en = 1'b1; mem_req = 1'b1; mem_we = 1'b1; data_address = a; data_out = d;
      @(negedge clk);
      mem_req = 1'b0; mem_we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      clk_en = 1'b1; mem_req = 1'b1; mem_we = 1'b0; data_address = a;
      @(negedge clk);
      mem_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 async_rst_n = 1'b0;
      #1;
      check("rst data_in", data_in, 8'h00);
      check("rst num_value", num_value, 8'h00);
      check("rst num_signed", {7'b0, num_signed}, 8'h00);
      check("rst char_valid", {7'b0, char_valid}, 8'h00);
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      async_rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 240; i++) wr(8'(i), 8'($urandom));

      // RAM round trip at both ends of the RAM window
      wr(8'h10, 8'h5A); rd(8'h10); check("ram 0x10", data_in, 8'h5A);
      wr(8'hEF, 8'hC3); rd(8'hEF); check("ram 0xEF", data_in, 8'hC3);
      rd(8'hF8); check("unmapped read", data_in, 8'h00);
      rd(8'hF0); check("write-only read", data_in, 8'h00);

      // Number display
      wr(8'hF0, 8'h80); wr(8'hF1, 8'h01);
      check("num set", num_value, 8'h80); check("sgn set", {7'b0, num_signed}, 8'h01);
      wr(8'hF2, 8'h00);
      check("num clr", num_value, 8'h00); check("sgn clr", {7'b0, num_signed}, 8'h00);

      // Fill past full, then drain in order
      char_ready = 1'b0;
      for (int i = 1; i <= 9; i++) wr(8'hF5, 8'(i));
      rd(8'hF7); check("status full+ovf", data_in, 8'hC8);
      rd(8'hF7); check("status ovf cleared", data_in, 8'h48);
      char_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("drain valid", {7'b0, char_valid}, 8'h01);
         check("drain order", char_data, 8'(i));
         @(negedge clk);
      end
      check("drained valid", {7'b0, char_valid}, 8'h00);
      char_ready = 1'b0;
      rd(8'hF7); check("status empty", data_in, 8'h20);

      // Push while full with a same-cycle pop; flush with a same-cycle pop
      for (int i = 0; i < 8; i++) wr(8'hF5, 8'(8'h60 + i));
      char_ready = 1'b1; wr(8'hF5, 8'hAA); char_ready = 1'b0;
      rd(8'hF7); check("push+pop full", data_in, 8'h48);
      char_ready = 1'b1; wr(8'hF6, 8'h00); char_ready = 1'b0;
      rd(8'hF7); check("flush+pop", data_in, 8'h20);
      for (int i = 0; i < 9; i++) wr(8'hF5, 8'(i));
      wr(8'hF6, 8'h00);
      rd(8'hF7); check("flush keeps ovf", data_in, 8'hA0);

      // clk_en low blocks both writes and reads
      wr(8'h20, 8'h11); rd(8'h10);
      clk_en = 1'b0; mem_req = 1'b1; mem_we = 1'b1; data_address = 8'h20; data_out = 8'h99;
      repeat (3) @(negedge clk);
      mem_we = 1'b0;
      repeat (2) @(negedge clk);
      check("clk_en hold", data_in, 8'h5A);
      mem_req = 1'b0;
      rd(8'h20); check("clk_en no write", data_in, 8'h11);

      // Asynchronous reset in the middle of a write burst
      wr(8'hF0, 8'h33); wr(8'hF5, 8'h41); wr(8'h30, 8'h77); rd(8'h10);
      clk_en = 1'b1; mem_req = 1'b1; mem_we = 1'b1; data_address = 8'h31; data_out = 8'h12;
      @(posedge clk);
      #2 async_rst_n = 1'b0;
      data_address = 8'h30; data_out = 8'hEE;
      #1;
      check("mid rst data_in", data_in, 8'h00);
      check("mid rst num", num_value, 8'h00);
      check("mid rst char_valid", {7'b0, char_valid}, 8'h00);
      @(negedge clk);
      @(negedge clk);
      mem_req = 1'b0; mem_we = 1'b0;
      async_rst_n = 1'b1;
      @(negedge clk);
`ifdef DMEM_RNG_EN
      rd(8'hF3); check("rng 1", data_in, 8'h01);
      rd(8'hF3); check("rng 2", data_in, 8'h02);
      rd(8'hF3); check("rng 3", data_in, 8'h04);
`else
      rd(8'hF3); check("rng 1", data_in, 8'h00);
      rd(8'hF3); check("rng 2", data_in, 8'h00);
      rd(8'hF3); check("rng 3", data_in, 8'h00);
`endif
      rd(8'h30); check("ram kept through rst", data_in, 8'h77);
      rd(8'h31); check("pre-rst write landed", data_in, 8'h12);
      rd(8'h10); check("ram 0x10 after rst", data_in, 8'h5A);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] a;
         clk_en  = ($urandom_range(0, 9) != 0);
         mem_req = ($urandom_range(0, 2) != 0);
         mem_we  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: a = 8'($urandom_range(0, 239));
            5, 6, 7, 8:    a = ($urandom_range(0, 1) == 1) ? 8'hF5 : 8'(8'hF0 + $urandom_range(0, 7));
            default:       a = 8'($urandom_range(240, 255));
         endcase
         if (a == 8'hF6 && $urandom_range(0, 3) != 0) a = 8'hF7;
         data_address = a;
         data_out     = 8'($urandom);
         char_ready   = ((i % 400) < 200) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
         if ((i % 4) == 0) buttons = 8'($urandom);
         @(negedge clk);
      end
      mem_req = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
